// File: rtl/cpu_pkg.sv
// ==================================================================
// cpu_pkg : shared fetch-stage state encoding and width constants (rev 1.0)
// ==================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    ERR   = 3'd4
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_watchdog.sv
// ==================================================================
// fetch_watchdog : counts unanswered request cycles, flags expiry (rev 1.0)
// ==================================================================
`default_nettype none

module fetch_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry is reported on the cycle that would complete ACK_TIMEOUT idle waits.
  assign expired = busy && !ack && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!busy || ack || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ==================================================================
// instr_fetch : single-outstanding instruction fetch with branch redirect (rev 1.0)
// Optional ack timeout / sticky error enabled by macro FETCH_TIMEOUT_EN.
// ==================================================================
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned PC_STEP     = PC_STEP_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_err
);

  fetch_state_e    state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] pc_next_d;
  logic            timeout;

`ifdef FETCH_TIMEOUT_EN
  logic wd_busy;
  assign wd_busy = (state_q == REQ) || (state_q == FLUSH);

  fetch_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (wd_busy),
    .ack     (imem_ack),
    .expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (ACK_TIMEOUT != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_err_d   = fetch_err_q;
    pc_next_d     = pc_cur;

    // A redirect outranks ack and accept everywhere except the error state.
    if (branch_taken && (state_q != ERR) && !timeout) begin
      pc_next_d     = branch_target;
      instr_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d     = REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = branch_taken ? branch_target : pc_cur;
      end
      REQ: begin
        if (timeout) begin
          state_d     = ERR;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
        end else if (branch_taken) begin
          if (imem_ack) begin
            imem_addr_d = branch_target;
          end else begin
            state_d = FLUSH;
          end
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = imem_addr_q;
          instr_valid_d = 1'b1;
          pc_next_d     = pc_cur + XLEN'(PC_STEP);
          state_d       = HOLD;
          imem_req_d    = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_d     = REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = branch_target;
        end else if (!stall) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
          imem_req_d    = 1'b1;
          imem_addr_d   = pc_cur;
        end
      end
      FLUSH: begin
        // The stale response still has to drain before the redirected fetch issues.
        if (timeout) begin
          state_d     = ERR;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
        end else if (imem_ack) begin
          state_d     = REQ;
          imem_addr_d = branch_taken ? branch_target : pc_cur;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign pc_next     = rst ? pc_cur : pc_next_d;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ==================================================================
// tb_instr_fetch : directed bench with a transaction-level fetch model (rev 1.0)
// ==================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int unsigned STEP = 4;
  localparam int unsigned TO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch #(
    .PC_STEP     (STEP),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_err     (fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one request may be outstanding; a redirect while it is
  // outstanding dooms its data; a captured instruction is held until accepted.
  bit          m_idle, m_req, m_doomed, m_valid, m_err;
  logic [31:0] m_addr, m_instr, m_pc;
  int          m_wait;

  int          wcnt, wcnt_nx, lat;
  bit          mute, force_ack, chk_on, to_now;
  logic [31:0] exp_pcn;

  task automatic model_reset();
    m_idle = 1; m_req = 0; m_doomed = 0; m_valid = 0; m_err = 0;
    m_addr = 0; m_instr = 0; m_pc = 0; m_wait = 0;
  endtask

  function automatic bit timeout_now();
`ifdef FETCH_TIMEOUT_EN
    return m_req && !m_err && !imem_ack && (m_wait == int'(TO) - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_pcn();
    if (rst || m_err) return pc_cur;
    if (timeout_now()) return pc_cur;
    if (branch_taken) return branch_target;
    if (m_req && !m_doomed && imem_ack) return pc_cur + STEP;
    return pc_cur;
  endfunction

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_err) begin
    end else if (m_idle) begin
      m_idle = 0; m_req = 1; m_wait = 0;
      m_addr = branch_taken ? branch_target : pc_cur;
      if (branch_taken) m_valid = 0;
    end else if (m_req) begin
      if (to_now) begin
        m_err = 1; m_req = 0;
      end else if (m_doomed) begin
        if (imem_ack) begin
          m_doomed = 0;
          m_addr   = branch_taken ? branch_target : pc_cur;
        end
      end else if (branch_taken) begin
        m_valid = 0;
        if (imem_ack) m_addr = branch_target;
        else m_doomed = 1;
      end else if (imem_ack) begin
        m_instr = mem_word(m_addr); m_pc = m_addr; m_valid = 1; m_req = 0;
      end
      m_wait = imem_ack ? 0 : m_wait + 1;
    end else begin
      if (branch_taken) begin
        m_valid = 0; m_req = 1; m_addr = branch_target;
      end else if (!stall) begin
        m_valid = 0; m_req = 1; m_addr = pc_cur;
      end
      m_wait = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("imem_req",    32'(imem_req),    32'(m_req));
      chk("imem_addr",   imem_addr,        m_addr);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr",       instr,            m_instr);
      chk("instr_pc",    instr_pc,         m_pc);
      chk("fetch_err",   32'(fetch_err),   32'(m_err));
      chk("pc_next",     pc_next,          model_pcn());
    end
  end

  task automatic half();
    if (rst) begin
      model_reset();
      wcnt = 0;
    end
    imem_ack = !rst && !mute && (force_ack || (imem_req && (wcnt >= lat)));
    @(negedge clk);
    exp_pcn = model_pcn();
    to_now  = timeout_now();
    wcnt_nx = (imem_req && !imem_ack) ? wcnt + 1 : 0;
  endtask

  task automatic fin();
    @(posedge clk);
    model_step();
    #1;
    wcnt         = rst ? 0 : wcnt_nx;
    pc_cur       = exp_pcn;
    branch_taken = 1'b0;
    force_ack    = 1'b0;
  endtask

  task automatic step();
    half();
    fin();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!instr_valid && n < max) begin
      step();
      n++;
    end
    chk("wait_valid", 32'(instr_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1; pc_cur = 32'h40; branch_taken = 1; branch_target = 32'h200;
    stall = 0; imem_ack = 0; lat = 0; mute = 0; force_ack = 0; wcnt = 0;
    model_reset();
    chk_on = 0;
    @(posedge clk); #1;
    chk_on = 1;

    // Reset: pc held even with a branch request present
    half();
    chk("rst_pc_next_hold", pc_next, 32'h40);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    fin();
    pc_cur = 32'h0;
    step();
    rst = 0;

    // First fetch from 0 with zero-wait memory
    step();
    chk("first_addr", imem_addr, 32'h0);
    chk("first_req", 32'(imem_req), 32'h1);
    half();
    chk("ack_pc_next", pc_next, 32'h4);
    fin();
    chk("first_instr", instr, 32'h00A0_0093);
    chk("first_instr_pc", instr_pc, 32'h0);
    chk("first_valid", 32'(instr_valid), 32'h1);

    // Stall three cycles in HOLD
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("stall_pc_next", pc_next, 32'h4);
      chk("stall_req", 32'(imem_req), 32'h0);
      fin();
      chk("stall_instr", instr, 32'h00A0_0093);
      chk("stall_valid", 32'(instr_valid), 32'h1);
    end
    stall = 0;
    step();
    chk("accept_addr", imem_addr, 32'h4);
    chk("accept_valid", 32'(instr_valid), 32'h0);
    step();
    chk("second_instr_pc", instr_pc, 32'h4);

    // Branch in REQ while ack is delayed 3 cycles
    lat = 3;
    step();
    chk("slow_addr", imem_addr, 32'h8);
    branch_taken = 1; branch_target = 32'h100;
    step();
    chk("flush_addr_held", imem_addr, 32'h8);
    chk("flush_req", 32'(imem_req), 32'h1);
    repeat (3) step();
    chk("redirect_addr", imem_addr, 32'h100);
    chk("redirect_valid", 32'(instr_valid), 32'h0);
    wait_valid(10);
    chk("redirect_instr_pc", instr_pc, 32'h100);
    chk("redirect_instr", instr, mem_word(32'h100));

    // Branch in REQ coincident with ack
    lat = 0;
    step();
    branch_taken = 1; branch_target = 32'h2000;
    step();
    chk("ack_branch_addr", imem_addr, 32'h2000);
    chk("ack_branch_valid", 32'(instr_valid), 32'h0);
    step();
    chk("ack_branch_pc", instr_pc, 32'h2000);

    // Branch in HOLD (while stalled) to the top word, then wrap
    stall = 1; branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    step();
    stall = 0;
    chk("hold_branch_addr", imem_addr, 32'hFFFF_FFFC);
    chk("hold_branch_valid", 32'(instr_valid), 32'h0);
    half();
    chk("wrap_pc_next", pc_next, 32'h0);
    fin();
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", imem_addr, 32'h0);

    // Second branch while flushing
    step();
    lat = 3;
    step();
    branch_taken = 1; branch_target = 32'h400;
    step();
    branch_taken = 1; branch_target = 32'h500;
    step();
    repeat (2) step();
    chk("flush_rebranch_addr", imem_addr, 32'h500);
    wait_valid(10);

    // Mixed directed traffic
    for (int i = 0; i < 40; i++) begin
      lat   = i % 3;
      stall = (i % 5 == 1);
      if (i % 7 == 3) begin
        branch_taken  = 1;
        branch_target = 32'h1000 + 32'(i) * 32'h10;
      end
      step();
    end

    // Reset mid-request, late ack while IDLE
    stall = 0; lat = 3; n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    rst = 1;
    half();
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_pc_next", pc_next, pc_cur);
    fin();
    rst = 0; force_ack = 1;
    step();
    chk("late_ack_valid", 32'(instr_valid), 32'h0);
    chk("late_ack_req", 32'(imem_req), 32'h1);
    chk("late_ack_addr", imem_addr, pc_cur);

    // Branch seen in IDLE
    rst = 1;
    step();
    rst = 0; branch_taken = 1; branch_target = 32'h700;
    step();
    chk("idle_branch_addr", imem_addr, 32'h700);

    // Memory never answers
    mute = 1; n = 0;
    while (!fetch_err && n < 40) begin
      step();
      n++;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("timeout_req", 32'(imem_req), 32'h0);
    branch_taken = 1; branch_target = 32'h900;
    half();
    chk("err_pc_next", pc_next, pc_cur);
    fin();
    repeat (3) step();
    chk("err_sticky", 32'(fetch_err), 32'h1);
    rst = 1;
    step();
    chk("err_cleared", 32'(fetch_err), 32'h0);
    rst = 0;
`else
    chk("no_timeout_err", 32'(fetch_err), 32'h0);
    chk("no_timeout_req", 32'(imem_req), 32'h1);
    chk("no_timeout_addr", imem_addr, 32'h700);
`endif
    mute = 0;
    step();

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
